// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector: shifts qualified samples into a
// history register and flags when a full window equals PATTERN.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_clr,
    input  logic                         i_valid,
    input  logic                         i_seq,
    output logic                         o_out,
    output logic                         o_pulse,
    output logic [CNT_W-1:0]             o_cnt,
    output logic [$clog2(PAT_W+1)-1:0]   o_dbg_fill,
    output logic [PAT_W-1:0]             o_dbg_hist
);

    localparam int               FW       = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);
    localparam logic [FW-1:0]    FILL_ONE = FW'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Valid-only input: a sample is consumed on every rising edge with
    // i_valid=1 and i_clr=0; there is no backpressure.
    logic [PAT_W-1:0] hist, hist_n;
    logic [FW-1:0]    fill, fill_n;
    logic             out_q, out_n;
    logic             pulse_q, pulse_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             match_cur, match_n;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hist    <= '0;
            fill    <= '0;
            out_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            hist    <= hist_n;
            fill    <= fill_n;
            out_q   <= out_n;
            pulse_q <= pulse_n;
            cnt_q   <= cnt_n;
        end
    end

    // The fill guard keeps a partially filled window (e.g. zeros out of reset)
    // from looking like a match.
    assign match_cur = (fill == FILL_MAX) && (hist == PATTERN);

    always_comb begin
        hist_n  = hist;
        fill_n  = fill;
        out_n   = out_q;
        pulse_n = 1'b0;
        cnt_n   = cnt_q;
        match_n = 1'b0;
        if (i_clr) begin
            hist_n = '0;
            fill_n = '0;
            out_n  = 1'b0;
            cnt_n  = '0;
        end else if (i_valid) begin
            hist_n = {hist[PAT_W-2:0], i_seq};
            if (!OVERLAP && match_cur) begin
                fill_n = FILL_ONE;
            end else if (fill < FILL_MAX) begin
                fill_n = fill + FILL_ONE;
            end
            match_n = (fill_n == FILL_MAX) && (hist_n == PATTERN);
            out_n   = match_n;
            pulse_n = match_n;
            if (match_n && (cnt_q != CNT_MAX)) begin
                cnt_n = cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        o_out      = out_q;
        o_pulse    = pulse_q;
        o_cnt      = cnt_q;
        o_dbg_fill = fill;
        o_dbg_hist = hist;
    end

endmodule
